// File: rtl/jt12_lfo_wave.sv
// jt12_lfo_wave: prescaled LFO phase accumulator with saw/triangle/square/noise waveform shaping.
// Build option JT12_LFO_NOISE_EN: wave=3 becomes sample-and-hold LFSR noise instead of inverted saw.
module jt12_lfo_wave #(
  parameter int MW = 7,
  parameter int CW = 7,
  parameter int OW = 8,
  parameter logic [8*CW-1:0] LIMITS = {CW'(5), CW'(8), CW'(44), CW'(62),
                                       CW'(67), CW'(71), CW'(78), CW'(108)}
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          zero,
  input  logic          lfo_rst,
  input  logic          lfo_en,
  input  logic [2:0]    lfo_freq,
  input  logic [1:0]    wave,
  output logic [MW-1:0] lfo_phase,
  output logic [OW-1:0] lfo_out,
  output logic          lfo_tick,
  output logic          lfo_wrap
);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic [CW-1:0] limit;
  logic [MW-1:0] phase_nxt;
  logic [MW-2:0] tri_val;
  logic [OW-1:0] saw_val;
  logic [OW-1:0] out_nxt;
  logic          clear;
  logic          step;

  assign limit = LIMITS[int'(lfo_freq)*CW +: CW];
  assign clear = !lfo_en || lfo_rst;
  // '>=' lets a freshly lowered limit step immediately instead of overrunning the counter
  assign step  = !clear && zero && (cnt >= limit);

  always_comb begin
    cnt_nxt   = cnt;
    phase_nxt = lfo_phase;
    if (clear) begin
      cnt_nxt   = '0;
      phase_nxt = '0;
    end else if (zero) begin
      if (cnt >= limit) begin
        cnt_nxt   = '0;
        phase_nxt = lfo_phase + 1'b1;
      end else begin
        cnt_nxt = cnt + 1'b1;
      end
    end
  end

`ifdef JT12_LFO_NOISE_EN
  logic [16:0]   lfsr;
  logic [16:0]   lfsr_shift;
  logic [16:0]   lfsr_nxt;
  logic [OW-1:0] noise;
  logic [OW-1:0] noise_nxt;

  assign lfsr_shift = {lfsr[15:0], lfsr[16] ^ lfsr[13]};

  // The noise sample only changes on a phase step, so it is held between steps.
  always_comb begin
    lfsr_nxt  = lfsr;
    noise_nxt = noise;
    if (clear) begin
      lfsr_nxt  = 17'd1;
      noise_nxt = '0;
    end else if (step) begin
      lfsr_nxt  = lfsr_shift;
      noise_nxt = lfsr_shift[OW-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr  <= 17'd1;
      noise <= '0;
    end else begin
      lfsr  <= lfsr_nxt;
      noise <= noise_nxt;
    end
  end
`endif

  // Shaping works on the next-state phase so lfo_out lines up with lfo_phase.
  always_comb begin
    saw_val = OW'(phase_nxt) << (OW - MW);
    tri_val = phase_nxt[MW-1] ? ~phase_nxt[MW-2:0] : phase_nxt[MW-2:0];
    out_nxt = '0;
    case (wave)
      2'd0:    out_nxt = saw_val;
      2'd1:    out_nxt = OW'(tri_val) << (OW - MW + 1);
      2'd2:    out_nxt = {OW{phase_nxt[MW-1]}};
`ifdef JT12_LFO_NOISE_EN
      default: out_nxt = noise_nxt;
`else
      default: out_nxt = ~saw_val;
`endif
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      lfo_phase <= '0;
      lfo_out   <= '0;
      lfo_tick  <= 1'b0;
      lfo_wrap  <= 1'b0;
    end else begin
      cnt       <= cnt_nxt;
      lfo_phase <= phase_nxt;
      lfo_out   <= out_nxt;
      lfo_tick  <= step;
      lfo_wrap  <= step && (&lfo_phase);
    end
  end

endmodule
